// File: rtl/bcd_display_scheduler.sv
// Shares one binary-to-BCD converter across hours/minutes/seconds, commits all
// six digits at once and scans them onto a multiplexed six-digit display.
module bcd_display_scheduler #(
    parameter int SCAN_DIV = 1000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] hours,
    input  logic [7:0] minutes,
    input  logic [7:0] seconds,
    input  logic       update,
    output logic [7:0] conv_value,
    input  logic [3:0] conv_hundreds,
    input  logic [3:0] conv_tens,
    input  logic [3:0] conv_ones,
    output logic       busy,
    output logic       overflow,
    output logic [5:0] digit_sel,
    output logic [3:0] digit_bcd
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [3:0] BLANK = 4'hF;

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t state, state_nxt;
    logic [1:0] fidx, fidx_nxt;
    logic start, capture, commit;
    logic pending;

    logic [7:0] snap_m, snap_s;
    logic [2:0][3:0] stg_tens, stg_ones;
    logic [2:0] stg_ovf;
    logic [5:0][3:0] disp, disp_nxt;

    logic [CW-1:0] scan_cnt;
    logic [2:0] scan_idx, scan_idx_nxt;
    logic scan_wrap;
    logic field_ovf;

    // Sequencer: one field per CONV cycle (0=H, 1=M, 2=S), then a single commit.
    always_comb begin
        state_nxt = state;
        fidx_nxt  = fidx;
        start     = 1'b0;
        capture   = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (update || pending) begin
                    start     = 1'b1;
                    fidx_nxt  = 2'd0;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                capture  = 1'b1;
                fidx_nxt = fidx + 2'd1;
                if (fidx == 2'd2) begin
                    fidx_nxt  = 2'd0;
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            fidx  <= 2'd0;
        end else begin
            state <= state_nxt;
            fidx  <= fidx_nxt;
        end
    end

    assign field_ovf = (conv_hundreds != 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending    <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            conv_value <= 8'd0;
            snap_m     <= 8'd0;
            snap_s     <= 8'd0;
            stg_tens   <= '0;
            stg_ones   <= '0;
            stg_ovf    <= '0;
            disp       <= '0;
        end else begin
            if (update && state != IDLE) begin
                pending <= 1'b1;
            end else if (start) begin
                pending <= 1'b0;
            end
            if (start) begin
                snap_m     <= minutes;
                snap_s     <= seconds;
                conv_value <= hours;
                busy       <= 1'b1;
            end
            if (capture) begin
                stg_tens[fidx] <= field_ovf ? BLANK : conv_tens;
                stg_ones[fidx] <= field_ovf ? BLANK : conv_ones;
                stg_ovf[fidx]  <= field_ovf;
                conv_value     <= (fidx == 2'd0) ? snap_m : snap_s;
            end
            if (commit) begin
                disp     <= disp_nxt;
                overflow <= |stg_ovf;
                busy     <= 1'b0;
            end
        end
    end

    // The scan reads the post-commit digits so a slot loaded on the commit edge is already fresh.
    always_comb begin
        disp_nxt = disp;
        if (commit) begin
            disp_nxt = {stg_tens[0], stg_ones[0], stg_tens[1], stg_ones[1],
                        stg_tens[2], stg_ones[2]};
        end
    end

    assign scan_wrap    = (scan_cnt == CNT_MAX);
    assign scan_idx_nxt = (scan_idx == 3'd5) ? 3'd0 : scan_idx + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt  <= '0;
            scan_idx  <= 3'd0;
            digit_sel <= 6'b000001;
            digit_bcd <= 4'h0;
        end else begin
            scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
            if (scan_wrap) begin
                scan_idx  <= scan_idx_nxt;
                digit_sel <= 6'b000001 << scan_idx_nxt;
                if (scan_idx_nxt == 3'd5 && BLANK_LZ && disp_nxt[5] == 4'd0) begin
                    digit_bcd <= BLANK;
                end else begin
                    digit_bcd <= disp_nxt[scan_idx_nxt];
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Randomised scoreboard bench: two scheduler instances (leading-zero blanking
// on and off) share stimulus and are checked against a request-level model.
module tb_bcd_display_scheduler;

    localparam int SD = 4;

    typedef struct packed {
        logic [5:0][3:0] d;
        logic            ovf;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [7:0] hours = 8'd0, minutes = 8'd0, seconds = 8'd0;
    logic update = 1'b0;

    logic [7:0] cv1, cv0;
    logic [3:0] ch1, ct1, co1, ch0, ct0, co0;
    logic busy1, busy0, ovf1, ovf0;
    logic [5:0] sel1, sel0;
    logic [3:0] bcd1, bcd0;

    int vectors = 0;
    int miscompares = 0;

    rec_t q[$];
    int m_rem = 0;
    bit m_pend = 1'b0;
    logic [7:0] m_snap[3];

    // Behavioural stand-ins for the shared combinational converter.
    assign ch1 = 4'(cv1 / 8'd100);
    assign ct1 = 4'((cv1 / 8'd10) % 8'd10);
    assign co1 = 4'(cv1 % 8'd10);
    assign ch0 = 4'(cv0 / 8'd100);
    assign ct0 = 4'((cv0 / 8'd10) % 8'd10);
    assign co0 = 4'(cv0 % 8'd10);

    bcd_display_scheduler #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .hours(hours), .minutes(minutes), .seconds(seconds),
        .update(update), .conv_value(cv1), .conv_hundreds(ch1), .conv_tens(ct1),
        .conv_ones(co1), .busy(busy1), .overflow(ovf1), .digit_sel(sel1), .digit_bcd(bcd1)
    );

    bcd_display_scheduler #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .hours(hours), .minutes(minutes), .seconds(seconds),
        .update(update), .conv_value(cv0), .conv_hundreds(ch0), .conv_tens(ct0),
        .conv_ones(co0), .busy(busy0), .overflow(ovf0), .digit_sel(sel0), .digit_bcd(bcd0)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rec_t convert(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        rec_t r;
        int v[3];
        v[0] = int'(s);
        v[1] = int'(m);
        v[2] = int'(h);
        r = '0;
        for (int f = 0; f < 3; f++) begin
            if (v[f] > 99) begin
                r.d[2*f]   = 4'hF;
                r.d[2*f+1] = 4'hF;
                r.ovf      = 1'b1;
            end else begin
                r.d[2*f]   = 4'(v[f] % 10);
                r.d[2*f+1] = 4'(v[f] / 10);
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] shown(input rec_t r, input int idx, input bit blank);
        if (idx == 5 && blank && r.d[5] == 4'd0) return 4'hF;
        return r.d[idx];
    endfunction

    // A request starts a 4-cycle conversion when idle; requests while running collapse into one.
    task automatic modelStep();
        if (m_rem == 0) begin
            if (update || m_pend) begin
                m_snap[0] = hours;
                m_snap[1] = minutes;
                m_snap[2] = seconds;
                q.push_back(convert(hours, minutes, seconds));
                m_rem  = 4;
                m_pend = 1'b0;
            end
        end else begin
            if (update) m_pend = 1'b1;
            m_rem--;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                                 input logic upd);
        hours   = h;
        minutes = m;
        seconds = s;
        update  = upd;
        @(posedge clk);
        if (!rst) modelStep();
        #2;
        update = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(hours, minutes, seconds, 1'b0);
    endtask

    task automatic doReset();
        rst    = 1'b1;
        m_rem  = 0;
        m_pend = 1'b0;
        q.delete();
        #1;
        checkOutput("reset_digit_sel", 32'(sel1), 32'h01);
        checkOutput("reset_digit_bcd", 32'(bcd1), 32'h0);
        checkOutput("reset_busy", 32'(busy1), 32'h0);
        checkOutput("reset_overflow", 32'(ovf1), 32'h0);
        checkOutput("reset_conv_value", 32'(cv1), 32'h0);
        applyStimulus(hours, minutes, seconds, 1'b0);
        rst = 1'b0;
    endtask

    // Monitor: pops a commit record whenever the DUT drops busy, then checks every scan cycle.
    initial begin
        int k;
        int idx;
        rec_t disp;
        logic [3:0] e1, e0;
        bit pb;
        bit rae;
        k = 0;
        disp = '0;
        e1 = 4'h0;
        e0 = 4'h0;
        pb = 1'b0;
        forever begin
            @(posedge clk);
            rae = rst;
            @(negedge clk);
            if (rae || rst) begin
                k    = 0;
                disp = '0;
                e1   = 4'h0;
                e0   = 4'h0;
                pb   = 1'b0;
            end else begin
                k++;
                if (pb && !busy1) begin
                    if (q.size() == 0) checkOutput("commit_expected", 32'h0, 32'h1);
                    else disp = q.pop_front();
                end
                pb = busy1;
                checkOutput("busy", 32'(busy1), 32'(m_rem != 0));
                checkOutput("busy_noblank", 32'(busy0), 32'(m_rem != 0));
                if (m_rem >= 2) checkOutput("conv_value", 32'(cv1), 32'(m_snap[4-m_rem]));
                checkOutput("overflow", 32'(ovf1), 32'(disp.ovf));
                idx = (k / SD) % 6;
                if (k % SD == 0) begin
                    e1 = shown(disp, idx, 1'b1);
                    e0 = shown(disp, idx, 1'b0);
                end
                checkOutput("digit_sel", 32'(sel1), 32'(6'b000001 << idx));
                checkOutput("digit_sel_noblank", 32'(sel0), 32'(6'b000001 << idx));
                checkOutput("digit_bcd", 32'(bcd1), 32'(e1));
                checkOutput("digit_bcd_noblank", 32'(bcd0), 32'(e0));
            end
        end
    end

    initial begin
        #2;
        doReset();
        idle(6*SD + 2);

        applyStimulus(8'd12, 8'd34, 8'd56, 1'b1);
        idle(30);
        applyStimulus(8'd7, 8'd34, 8'd56, 1'b1);
        idle(30);

        applyStimulus(8'd1, 8'd150, 8'd2, 1'b1);
        idle(30);
        applyStimulus(8'd1, 8'd10, 8'd2, 1'b1);
        idle(30);

        applyStimulus(8'd11, 8'd22, 8'd33, 1'b1);
        applyStimulus(8'd44, 8'd55, 8'd6, 1'b1);
        applyStimulus(8'd45, 8'd56, 8'd7, 1'b0);
        applyStimulus(8'd46, 8'd57, 8'd8, 1'b1);
        applyStimulus(8'd46, 8'd57, 8'd8, 1'b1);
        idle(40);

        applyStimulus(8'd1, 8'd2, 8'd3, 1'b1);
        idle(3);
        applyStimulus(8'd4, 8'd5, 8'd6, 1'b1);
        idle(30);

        applyStimulus(8'd12, 8'd34, 8'd56, 1'b1);
        idle(30);
        applyStimulus(8'd99, 8'd98, 8'd97, 1'b1);
        applyStimulus(8'd99, 8'd98, 8'd97, 1'b0);
        doReset();
        idle(6*SD);
        applyStimulus(8'd21, 8'd43, 8'd5, 1'b1);
        idle(30);

        repeat (1500) begin
            logic [7:0] h, m, s;
            h = hours;
            m = minutes;
            s = seconds;
            if ($urandom_range(0, 3) == 0)
                h = 8'($urandom_range(0, ($urandom_range(0, 7) == 0) ? 255 : 99));
            if ($urandom_range(0, 3) == 0)
                m = 8'($urandom_range(0, ($urandom_range(0, 7) == 0) ? 255 : 99));
            if ($urandom_range(0, 3) == 0)
                s = 8'($urandom_range(0, ($urandom_range(0, 7) == 0) ? 255 : 99));
            applyStimulus(h, m, s, 1'($urandom_range(0, 5) == 0));
        end
        idle(30);
        checkOutput("queue_drained", 32'(q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd_display_scheduler.md
Name: bcd_display_scheduler

Overview:
Time-shares one combinational binary-to-BCD converter (8-bit in; hundreds/tens/ones out) across the clock's hours, minutes and seconds fields. On each update request it snapshots the three binary fields and converts them sequentially through the shared converter. It then commits six BCD digits atomically and scans them onto a multiplexed six-digit display. It sits between the timekeeping counters and the 7-segment decoder.

Parameters:
SCAN_DIV, 1000, clk cycles per display digit slot (>=2)
BLANK_LZ, 1, 1 = blank hours-tens digit when it is 0

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
hours  in  8  binary hours field (0..99 valid)
minutes  in  8  binary minutes field (0..99 valid)
seconds  in  8  binary seconds field (0..99 valid)
update  in  1  single-cycle request to reconvert/commit
conv_value  out  8  operand driven to shared converter (registered)
conv_hundreds  in  4  converter result
conv_tens  in  4  converter result
conv_ones  in  4  converter result
busy  out  1  conversion sequence in progress
overflow  out  1  last commit had a field >99
digit_sel  out  6  one-hot digit enable; bit5=hours tens ... bit0=seconds ones
digit_bcd  out  4  BCD code for selected digit; 4'hF = blank

Behaviour:
- Reset (async, rst=1): FSM=IDLE, pending=0, busy=0, overflow=0, conv_value=0, all six committed digits=0, scan counter=0, digit index=0, digit_sel=6'b000001, digit_bcd=4'h0.
- FSM states: IDLE, CONV (field index 0=H, 1=M, 2=S), COMMIT.
- IDLE, update=1 or pending=1 at edge E0: snapshot hours/minutes/seconds, conv_value<=hours, index=0, pending<=0, busy<=1, go to CONV.
- CONV edges E1/E2/E3: capture converter outputs for the current index into staging, load conv_value with the next field's snapshot, index++. After E3 (S captured), go to COMMIT.
- COMMIT edge E4: copy staging into the display digit registers atomically; set overflow to the OR of the per-field flags; busy<=0; return to IDLE.
- Timing: busy high E0..E4 (4 cycles). New digits are visible on the next scan slot loaded at or after E4. The next request may start at E5 at the earliest.
- Field overflow: if conv_hundreds!=0, both digits of that field commit as 4'hF. Other fields are unaffected.
- update while busy (including at E4): set pending. Exactly one further sequence starts at the IDLE edge after COMMIT. Multiple updates while busy collapse into one.
- Snapshot isolation: field inputs changing during CONV/COMMIT do not affect the in-flight sequence.
- Scan: the counter counts 0..SCAN_DIV-1. At wrap, the digit index advances 0..5 and wraps 5->0. digit_sel and digit_bcd are registered together at the same edge and are always consistent.
- Index k selects: 0=S ones, 1=S tens, 2=M ones, 3=M tens, 4=H ones, 5=H tens.
- BLANK_LZ=1 and committed hours tens==0: index 5 outputs 4'hF.
- Scanning runs continuously and independently of the FSM, including while busy. During busy, displayed digits hold their old committed values; there is no tearing.
- Reset mid-sequence: abandon the sequence. Staging is discarded, committed digits return to 0, and pending is cleared.

Test Plan:
- Reset -> digit_sel=000001, digit_bcd=0, busy=0, overflow=0, conv_value=0; release and hold 6*SCAN_DIV cycles -> digits 0,0,0,0,0 then F at index 5 (BLANK_LZ=1).
- H=12,M=34,S=56, update pulse -> conv_value 12,34,56 on consecutive cycles; busy high exactly 4 cycles; scan yields 6,5,4,3,2,1 for indices 0..5.
- H=7 -> index 5 shows F, index 4 shows 7. Repeat with BLANK_LZ=0 -> index 5 shows 0.
- M=150 (converter hundreds=1), H=1,S=2 -> minute digits both F, overflow=1. Next update with M=10 -> overflow=0, digits 0,1.
- update pulsed 3 times during busy, fields changed mid-sequence -> first commit uses the original snapshot; exactly one extra 4-cycle sequence follows with the new values; no third sequence.
- Assert rst at CONV index 1 after a prior commit of 12:34:56 -> all digits 0, busy 0; a fresh update after release converts normally.
